// File: rtl/bound_flasher_bar.sv
// Bounded lamp-bar flasher: a level register stepped up/down between programmable
// bounds with saturate/wrap/bounce behaviour, decoded to a bar or dot lamp vector.
module bound_flasher_bar #(
    parameter  int WIDTH = 16,
    localparam int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             ison,
    input  logic             load,
    input  logic [LW-1:0]    load_val,
    input  logic [LW-1:0]    lo_bound,
    input  logic [LW-1:0]    hi_bound,
    input  logic [1:0]       bnd_mode,
    input  logic             dot,
    output logic [LW-1:0]    level,
    output logic [WIDTH-1:0] out,
    output logic             hit_hi,
    output logic             hit_lo,
    output logic             cfg_err
);

    localparam logic [1:0]    MODE_WRAP   = 2'b01;
    localparam logic [1:0]    MODE_BOUNCE = 2'b10;
    localparam logic [LW-1:0] MAX_LVL     = LW'(WIDTH);
    localparam logic [LW-1:0] ONE_LVL     = LW'(1);

    function automatic logic [LW-1:0] sat_width(input logic [LW-1:0] v);
        if (v > MAX_LVL) begin
            return MAX_LVL;
        end else begin
            return v;
        end
    endfunction

    // Upper limit applied first, so an inverted range resolves to lo.
    function automatic logic [LW-1:0] clamp_range(input logic [LW-1:0] v,
                                                  input logic [LW-1:0] lo,
                                                  input logic [LW-1:0] hi);
        logic [LW-1:0] t;
        t = (v > hi) ? hi : v;
        return (t < lo) ? lo : t;
    endfunction

    logic [LW-1:0]    lo_s;
    logic [LW-1:0]    hi_s;
    logic [LW-1:0]    load_s;
    logic [LW-1:0]    up_val_s;
    logic [LW-1:0]    dn_val_s;
    logic             cfg_err_s;
    logic             eff_up_s;
    logic [LW-1:0]    level_nxt_s;
    logic             dir_nxt_s;
    logic             hit_hi_nxt_s;
    logic             hit_lo_nxt_s;
    logic [WIDTH-1:0] out_s;
    logic [LW-1:0]    level_r;
    logic             dir_r;
    logic             hit_hi_r;
    logic             hit_lo_r;

    assign lo_s      = sat_width(lo_bound);
    assign hi_s      = sat_width(hi_bound);
    assign load_s    = clamp_range(sat_width(load_val), lo_s, hi_s);
    assign cfg_err_s = (lo_s > hi_s);
    assign eff_up_s  = (bnd_mode == MODE_BOUNCE) ? dir_r : ison;
    assign up_val_s  = level_r + ONE_LVL;
    assign dn_val_s  = level_r - ONE_LVL;

    // Next level / direction / edge-pulse selection, priority load > step > hold.
    always_comb begin
        level_nxt_s  = level_r;
        dir_nxt_s    = dir_r;
        hit_hi_nxt_s = 1'b0;
        hit_lo_nxt_s = 1'b0;
        if (load) begin
            level_nxt_s = load_s;
            dir_nxt_s   = ison;
        end else if (enb) begin
            if (cfg_err_s) begin
                level_nxt_s = level_r;
            end else if (level_r < lo_s) begin
                level_nxt_s = lo_s;
            end else if (level_r > hi_s) begin
                level_nxt_s = hi_s;
            end else if (lo_s == hi_s) begin
                if (bnd_mode == MODE_BOUNCE) begin
                    dir_nxt_s = ~dir_r;
                end else begin
                    dir_nxt_s = dir_r;
                end
            end else if (eff_up_s) begin
                if (level_r < hi_s) begin
                    level_nxt_s  = up_val_s;
                    hit_hi_nxt_s = (up_val_s == hi_s);
                end else begin
                    case (bnd_mode)
                        MODE_WRAP: begin
                            level_nxt_s  = lo_s;
                            hit_lo_nxt_s = 1'b1;
                        end
                        MODE_BOUNCE: dir_nxt_s = 1'b0;
                        default:     level_nxt_s = level_r;
                    endcase
                end
            end else begin
                if (level_r > lo_s) begin
                    level_nxt_s  = dn_val_s;
                    hit_lo_nxt_s = (dn_val_s == lo_s);
                end else begin
                    case (bnd_mode)
                        MODE_WRAP: begin
                            level_nxt_s  = hi_s;
                            hit_hi_nxt_s = 1'b1;
                        end
                        MODE_BOUNCE: dir_nxt_s = 1'b1;
                        default:     level_nxt_s = level_r;
                    endcase
                end
            end
        end else begin
            level_nxt_s = level_r;
        end
    end

    // State and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r  <= {LW{1'b0}};
            dir_r    <= 1'b1;
            hit_hi_r <= 1'b0;
            hit_lo_r <= 1'b0;
        end else begin
            level_r  <= level_nxt_s;
            dir_r    <= dir_nxt_s;
            hit_hi_r <= hit_hi_nxt_s;
            hit_lo_r <= hit_lo_nxt_s;
        end
    end

    // Lamp decode straight from the level register so out tracks level and dot.
    always_comb begin
        out_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (dot) begin
                out_s[i] = (LW'(i + 1) == level_r);
            end else begin
                out_s[i] = (LW'(i) < level_r);
            end
        end
    end

    assign level   = level_r;
    assign out     = out_s;
    assign hit_hi  = hit_hi_r;
    assign hit_lo  = hit_lo_r;
    assign cfg_err = cfg_err_s;

endmodule
